// File: rtl/adc_avg_fifo_if.sv
// Sample-in / result-out bus of the ADC averaging stage.
// master: the averager (consumes samples, drives the result stream).
// slave : the surrounding logic (drives samples, accepts results).
interface adc_avg_fifo_if;
  logic [15:0] in_sample;
  logic        in_valid;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    input  in_sample,
    input  in_valid,
    input  out_ready,
    output out_data,
    output out_valid
  );

  modport slave (
    output in_sample,
    output in_valid,
    output out_ready,
    input  out_data,
    input  out_valid
  );
endinterface

// File: rtl/adc_avg_fifo.sv
// Per-slot averager of the tagged ADC sample stream feeding a show-ahead result FIFO.
// Each of 8 slots sums 2^AVG_LOG2 samples; the finished average is pushed tagged.
// Optional build macro ADC_AVG_ROUND_EN: round-half-up with saturation instead of truncation.
module adc_avg_fifo #(
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  adc_avg_fifo_if.master              bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned SW = 12 + AVG_LOG2;
  localparam int unsigned CW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;

  logic [SW-1:0]   acc [8];
  logic [CW-1:0]   cnt [8];
  logic [15:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  logic [2:0]      slot;
  logic [11:0]     code;
  logic            unused_msb;
  logic [SW-1:0]   sum;
  logic            last;
  logic [11:0]     result;
  logic            full;
  logic            pop;
  logic            done;
  logic            accept;

  assign slot       = bus.in_sample[14:12];
  assign code       = bus.in_sample[11:0];
  assign unused_msb = bus.in_sample[15];

  // Running sum including the current sample; final-sample detect for its slot
  always_comb begin
    sum  = acc[slot] + SW'(code);
    last = (AVG_LOG2 == 0) || (cnt[slot] == {CW{1'b1}});
  end

`ifdef ADC_AVG_ROUND_EN
  localparam int unsigned RW  = SW + 1;
  localparam int unsigned RND = (2 ** AVG_LOG2) / 2;
  logic [RW-1:0] rnd_sum;
  logic [RW-1:0] rnd_shr;

  // Round half up, clamp to full-scale code
  always_comb begin
    rnd_sum = {1'b0, sum} + RW'(RND);
    rnd_shr = rnd_sum >> AVG_LOG2;
    result  = (rnd_shr > RW'(12'hFFF)) ? 12'hFFF : rnd_shr[11:0];
  end
`else
  // Truncating divide by the sample count
  always_comb begin
    result = 12'(sum >> AVG_LOG2);
  end
`endif

  // FIFO handshake: a pop frees the slot a same-cycle write needs when full
  always_comb begin
    full   = (fifo_level == LW'(FIFO_DEPTH));
    pop    = bus.out_valid && bus.out_ready;
    done   = bus.in_valid && last;
    accept = done && (!full || pop);
  end

  assign bus.out_valid = (fifo_level != '0);
  assign bus.out_data  = mem[rd_ptr];

  // Per-slot accumulate; only the addressed slot changes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else if (clr) begin
      for (int i = 0; i < 8; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else if (bus.in_valid) begin
      if (last) begin
        acc[slot] <= '0;
        cnt[slot] <= '0;
      end else begin
        acc[slot] <= sum;
        cnt[slot] <= cnt[slot] + CW'(1);
      end
    end
  end

  // Result FIFO storage, pointers, level and sticky drop flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= {1'b0, slot, result};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({accept, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (done && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_avg_fifo.sv
// Self-checking bench for adc_avg_fifo (AVG_LOG2=2, FIFO_DEPTH=4).
// Expected averages come from a stimulus table and hand sequences; popped words
// are checked against a scoreboard queue. Honours ADC_AVG_ROUND_EN if defined.
module tb_adc_avg_fifo;

  localparam int unsigned AVG_LOG2   = 2;
  localparam int unsigned FIFO_DEPTH = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr   = 1'b0;
  logic [2:0] fifo_level;
  logic       overflow;

  adc_avg_fifo_if bus ();

  adc_avg_fifo #(
    .AVG_LOG2  (AVG_LOG2),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .bus       (bus),
    .fifo_level(fifo_level),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  slot;
    logic [11:0] c0, c1, c2, c3;
    logic [15:0] exp;
  } vec_t;

  vec_t        tbl [5];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q [$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: check any pop seen before the edge, then step to edge+1
  task automatic tick();
    logic [15:0] e;
    @(negedge clk);
    if (bus.out_valid && bus.out_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pop_unexpected: got %h, expected no word", bus.out_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.out_data !== e) begin
          n_err++;
          $display("FAIL pop_data: got %h, expected %h", bus.out_data, e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] s, input logic [11:0] c);
    bus.in_sample = {1'b0, s, c};
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
  endtask

  task automatic avg4(input logic [2:0] s, input logic [11:0] c, input logic push);
    send(s, c);
    send(s, c);
    send(s, c);
    if (push) exp_q.push_back({1'b0, s, c});
    send(s, c);
  endtask

  task automatic drain(input int cycles);
    bus.out_ready = 1'b1;
    for (int i = 0; i < cycles; i++) tick();
    chk("drain_queue_empty", 16'(exp_q.size()), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef ADC_AVG_ROUND_EN
    tbl[0] = '{3'd3, 12'd100, 12'd101, 12'd102, 12'd103, 16'h3066};
    tbl[1] = '{3'd2, 12'd0,   12'd0,   12'd0,   12'd3,   16'h2001};
    tbl[3] = '{3'd6, 12'd1,   12'd2,   12'd3,   12'd4,   16'h6003};
    tbl[4] = '{3'd4, 12'd7,   12'd0,   12'd0,   12'd0,   16'h4002};
`else
    tbl[0] = '{3'd3, 12'd100, 12'd101, 12'd102, 12'd103, 16'h3065};
    tbl[1] = '{3'd2, 12'd0,   12'd0,   12'd0,   12'd3,   16'h2000};
    tbl[3] = '{3'd6, 12'd1,   12'd2,   12'd3,   12'd4,   16'h6002};
    tbl[4] = '{3'd4, 12'd7,   12'd0,   12'd0,   12'd0,   16'h4001};
`endif
    tbl[2] = '{3'd5, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 16'h5FFF};

    bus.in_sample = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    chk("reset_out_valid", 16'(bus.out_valid), 16'd0);
    chk("reset_out_data", bus.out_data, 16'h0000);
    chk("reset_level", 16'(fifo_level), 16'd0);
    chk("reset_overflow", 16'(overflow), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table: one average per record, latency checked around the final sample
    bus.out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      send(tbl[v].slot, tbl[v].c0);
      send(tbl[v].slot, tbl[v].c1);
      send(tbl[v].slot, tbl[v].c2);
      chk("pre_final_out_valid", 16'(bus.out_valid), 16'd0);
      exp_q.push_back(tbl[v].exp);
      send(tbl[v].slot, tbl[v].c3);
      chk("post_final_out_valid", 16'(bus.out_valid), 16'd1);
      chk("post_final_out_data", bus.out_data, tbl[v].exp);
    end
    drain(4);

    // Interleaved slots 0 and 7
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(16'h0004);
      send(3'd0, 12'd4);
      if (i == 3) exp_q.push_back(16'h7008);
      send(3'd7, 12'd8);
    end
    drain(4);
    chk("interleave_level", 16'(fifo_level), 16'd0);

    // Overflow: five averages with no reader, the fifth dropped
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) avg4(3'(i), 12'(i + 1), i < 4);
    chk("ovf_level", 16'(fifo_level), 16'd4);
    chk("ovf_flag", 16'(overflow), 16'd1);
    chk("ovf_head", bus.out_data, 16'h0001);
    drain(6);
    chk("ovf_drained_level", 16'(fifo_level), 16'd0);
    chk("ovf_sticky", 16'(overflow), 16'd1);
    bus.out_ready = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_overflow", 16'(overflow), 16'd0);

    // Full FIFO with a pop on the same edge as a completing write
    for (int i = 0; i < 4; i++) avg4(3'(i), 12'(i + 1), 1'b1);
    send(3'd5, 12'd50);
    send(3'd5, 12'd50);
    send(3'd5, 12'd50);
    bus.out_ready = 1'b1;
    exp_q.push_back(16'h5032);
    send(3'd5, 12'd50);
    bus.out_ready = 1'b0;
    chk("full_pop_level", 16'(fifo_level), 16'd4);
    chk("full_pop_overflow", 16'(overflow), 16'd0);
    drain(6);
    chk("full_pop_drained", 16'(fifo_level), 16'd0);
    chk("empty_ready_no_underflow", 16'(bus.out_valid), 16'd0);

    // Async reset mid-accumulation with a full, overflowed FIFO
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) avg4(3'(i), 12'(i + 1), 1'b0);
    send(3'd1, 12'd1000);
    send(3'd1, 12'd1000);
    rst_n = 1'b0;
    #2;
    chk("rst_mid_out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_mid_level", 16'(fifo_level), 16'd0);
    chk("rst_mid_overflow", 16'(overflow), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    avg4(3'd1, 12'd20, 1'b1);
    drain(3);

    // Synchronous clear mid-accumulation, also overriding a same-cycle sample
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) avg4(3'(i), 12'(i + 1), 1'b0);
    send(3'd1, 12'd1000);
    send(3'd1, 12'd1000);
    clr           = 1'b1;
    bus.in_sample = {1'b0, 3'd1, 12'd1000};
    bus.in_valid  = 1'b1;
    tick();
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    chk("clr_mid_out_valid", 16'(bus.out_valid), 16'd0);
    chk("clr_mid_level", 16'(fifo_level), 16'd0);
    chk("clr_mid_overflow", 16'(overflow), 16'd0);
    bus.out_ready = 1'b1;
    avg4(3'd1, 12'd20, 1'b1);
    drain(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
